// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its future receiver.
package serial_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BIT_DIV = 4;
  // Bit-period counter width; covers the full legal divider range up to 255.
  localparam int TIMER_W     = 8;

  // Clock cycles occupied by one frame: start + data + optional parity + stop.
  function automatic int frame_cycles(int data_w, int bit_div, int parity_en);
    return (data_w + 2 + parity_en) * bit_div;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter: tick marks the last cycle of a bit period.
// A load restarts the period, so the bit in flight lasts exactly DIV cycles.
module bit_timer
  import serial_pkg::*;
#(
  parameter int DIV = DEF_BIT_DIV
) (
  input  logic clk,
  input  logic CLRN,
  input  logic load,
  output logic tick
);

  logic [TIMER_W-1:0] r_cnt;

  // Reload on bit boundaries, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN)             r_cnt <= '0;
    else if (load)         r_cnt <= TIMER_W'(DIV - 1);
    else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W bits LSB first, optional even
// parity, stop bit. tx_line is registered and idles high.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BIT_DIV   = DEF_BIT_DIV,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              CLRN,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_parity;
  logic              r_line;
  logic              w_accept;
  logic              w_tick;
  logic              w_load;
  logic              w_last_bit;
  logic              w_par_bit;

  assign tx_ready    = (r_state == ST_IDLE);
  assign busy        = ~tx_ready;
  assign w_accept    = tx_valid & tx_ready;
  assign done        = (r_state == ST_STOP) & w_tick;
  assign w_load      = w_accept | (busy & w_tick);
  assign w_last_bit  = (r_bit_cnt == CNT_W'(DATA_W - 1));
  assign w_shift_nxt = r_shift >> 1;
  // After the last data bit the line carries parity, or goes straight to stop.
  assign w_par_bit   = (PARITY_EN != 0) ? r_parity : 1'b1;
  assign tx_line     = r_line;

  bit_timer #(.DIV(BIT_DIV)) u_bit_timer (
    .clk  (clk),
    .CLRN (CLRN),
    .load (w_load),
    .tick (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: every non-idle state lasts one bit time (one tick)
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_START;
      ST_START:  if (w_tick)   w_state_nxt = ST_DATA;
      ST_DATA:   if (w_tick && w_last_bit)
                   w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_tick)   w_state_nxt = ST_STOP;
      ST_STOP:   if (w_tick)   w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch word on accept, drive the line with the bit of the
  // state being entered so tx_line stays a plain register output.
  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_line    <= 1'b1;
    end else if (w_accept) begin
      r_shift   <= tx_data;
      r_bit_cnt <= '0;
      r_parity  <= ^tx_data;
      r_line    <= 1'b0;
    end else if (busy && w_tick) begin
      unique case (r_state)
        ST_START: r_line <= r_shift[0];
        ST_DATA: begin
          r_shift   <= w_shift_nxt;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_line    <= w_last_bit ? w_par_bit : w_shift_nxt[0];
        end
        ST_PARITY: r_line <= 1'b1;
        ST_STOP:   r_line <= 1'b1;
        default:   r_line <= 1'b1;
      endcase
    end
  end

endmodule
